// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter with optional parity, 1/2 stop bits and runtime baud divisor
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  stop_bits,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  output logic                  S_DATA,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [IW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  par_en_q, par_en_d, par_q, par_d, stop_q, stop_d;
  logic                  s_data_q, s_data_d, busy_q, busy_d, done_q, done_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop_q   <= 1'b0;
      s_data_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop_q   <= stop_d;
      s_data_q <= s_data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Data goes out of a right-shifting copy of the word; the parity bit is fixed at acceptance.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop_d   = stop_q;
    s_data_d = s_data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      s_data_d = 1'b1;
      busy_d   = 1'b0;
      if (Data_Valid) begin
        state_d  = START;
        sh_d     = P_DATA;
        par_en_d = parity_enable;
        par_d    = (^P_DATA) ^ parity_type;
        stop_d   = stop_bits;
        div_d    = baud_div;
        cnt_d    = baud_div;
        bit_d    = '0;
        s_data_d = 1'b0;
        busy_d   = 1'b1;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = div_q;
      case (state_q)
        START: begin
          state_d  = DATA;
          bit_d    = '0;
          s_data_d = sh_q[0];
          sh_d     = sh_q >> 1;
        end
        DATA: begin
          if (bit_q == LAST_BIT) begin
            state_d  = par_en_q ? PARITY : STOP;
            s_data_d = par_en_q ? par_q : 1'b1;
            bit_d    = '0;
          end else begin
            bit_d    = bit_q + 1'b1;
            s_data_d = sh_q[0];
            sh_d     = sh_q >> 1;
          end
        end
        PARITY: begin
          state_d  = STOP;
          s_data_d = 1'b1;
          bit_d    = '0;
        end
        default: begin
          // bit_q counts completed stop periods when two are requested
          if (stop_q && bit_q == '0) begin
            bit_d = IW'(1);
          end else begin
            state_d  = IDLE;
            s_data_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            bit_d    = '0;
          end
        end
      endcase
    end
  end

  assign S_DATA  = s_data_q;
  assign busy    = busy_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for 8-bit and 5-bit uart_tx_param instances
module tb_uart_tx_param;
  logic       CLK, RST;
  logic [7:0] P_DATA, baud_div;
  logic [4:0] p_data5;
  logic       Data_Valid, dv5, parity_enable, parity_type, stop_bits;
  logic       S_DATA, busy, tx_done, s5, busy5, done5;
  int         vec, err;
  logic [2:0] sq[$];
  logic [2:0] sq5[$];

  uart_tx_param #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .parity_enable(parity_enable), .parity_type(parity_type), .stop_bits(stop_bits),
    .baud_div(baud_div), .S_DATA(S_DATA), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_param #(.DATA_WIDTH(5), .DIV_WIDTH(8)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(p_data5), .Data_Valid(dv5),
    .parity_enable(parity_enable), .parity_type(parity_type), .stop_bits(stop_bits),
    .baud_div(baud_div), .S_DATA(s5), .busy(busy5), .tx_done(done5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard entry per cycle: {tx_done, busy, S_DATA}; frame ends with the done/idle cycle.
  task automatic push_frame(input logic [7:0] d, input int w, input logic pe, pt, sb,
                            input logic [7:0] div, input bit to5);
    logic b[$];
    logic p;
    p = pt;
    b.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      b.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) b.push_back(p);
    b.push_back(1'b1);
    if (sb) b.push_back(1'b1);
    foreach (b[i])
      for (int k = 0; k <= int'(div); k++)
        if (to5) sq5.push_back({2'b01, b[i]}); else sq.push_back({2'b01, b[i]});
    if (to5) sq5.push_back(3'b101); else sq.push_back(3'b101);
  endtask

  task automatic drain(input string nm, input int max);
    logic [2:0] e;
    int n;
    n = 0;
    while (sq.size() > 0 && (max == 0 || n < max)) begin
      @(negedge CLK);
      e = sq.pop_front();
      vec++;
      if ({tx_done, busy, S_DATA} !== e) begin
        err++;
        $display("FAIL %s cyc %0d: tx_done/busy/S_DATA=%b want %b", nm, n + 1, {tx_done, busy, S_DATA}, e);
      end
      n++;
    end
  endtask

  task automatic test_frame(input string nm, input logic [7:0] d, input logic pe, pt, sb,
                            input logic [7:0] div);
    push_frame(d, 8, pe, pt, sb, div, 1'b0);
    @(posedge CLK); #1;
    P_DATA = d; parity_enable = pe; parity_type = pt; stop_bits = sb; baud_div = div;
    Data_Valid = 1'b1;
    @(posedge CLK); #1;
    // scramble inputs mid-frame: only the latched copies may matter
    Data_Valid = 1'b0; P_DATA = ~d; parity_enable = ~pe; parity_type = ~pt;
    stop_bits = ~sb; baud_div = ~div;
    drain(nm, 0);
    @(negedge CLK);
    vec++;
    if (tx_done !== 1'b0) begin
      err++;
      $display("FAIL %s done_pulse: tx_done=%b want 0", nm, tx_done);
    end
  endtask

  task automatic test_reset;
    #12;
    vec++;
    if ({tx_done, busy, S_DATA, done5, busy5, s5} !== 6'b001001) begin
      err++;
      $display("FAIL reset_state: got %b want 001001", {tx_done, busy, S_DATA, done5, busy5, s5});
    end
    Data_Valid = 1'b1; P_DATA = 8'hFF;
    @(posedge CLK); #1;
    vec++;
    if ({busy, S_DATA} !== 2'b01) begin
      err++;
      $display("FAIL reset_no_accept: busy/S_DATA=%b want 01", {busy, S_DATA});
    end
    Data_Valid = 1'b0;
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_basic;
    logic [9:0] ref_bits;
    logic [2:0] first;
    ref_bits = 10'b1101001010;
    push_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    first = sq[0];
    vec++;
    for (int i = 0; i < 10; i++)
      if (sq[i][0] !== ref_bits[i]) begin
        err++;
        $display("FAIL basic_model bit %0d: got %b want %b", i, sq[i][0], ref_bits[i]);
      end
    sq.delete();
    if (first !== 3'b010) $display("note: model start entry %b", first);
    test_frame("basic_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_parity;
    test_frame("parity_even", 8'hA5, 1'b1, 1'b0, 1'b0, 8'd0);
    test_frame("parity_odd", 8'hA5, 1'b1, 1'b1, 1'b0, 8'd0);
  endtask

  task automatic test_baud;
    test_frame("baud3_2stop", 8'h0F, 1'b1, 1'b1, 1'b1, 8'd3);
    test_frame("baud1_even", 8'h3C, 1'b1, 1'b0, 1'b1, 8'd1);
  endtask

  task automatic test_back_to_back;
    push_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    push_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge CLK); #1;
    P_DATA = 8'h11; parity_enable = 1'b0; parity_type = 1'b0; stop_bits = 1'b0; baud_div = 8'd0;
    Data_Valid = 1'b1;
    @(posedge CLK); #1;
    P_DATA = 8'h22;
    drain("b2b_first", 11);
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    drain("b2b_second", 0);
  endtask

  task automatic test_mid_reset;
    push_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge CLK); #1;
    P_DATA = 8'hA5; parity_enable = 1'b0; stop_bits = 1'b0; baud_div = 8'd0; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    drain("rst_pre", 4);
    sq.delete();
    @(negedge CLK); #2;
    RST = 1'b1;
    #1;
    vec++;
    if ({tx_done, busy, S_DATA} !== 3'b001) begin
      err++;
      $display("FAIL rst_async: tx_done/busy/S_DATA=%b want 001", {tx_done, busy, S_DATA});
    end
    P_DATA = 8'h3C; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    vec++;
    if ({tx_done, busy, S_DATA} !== 3'b001) begin
      err++;
      $display("FAIL rst_hold: tx_done/busy/S_DATA=%b want 001", {tx_done, busy, S_DATA});
    end
    push_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    drain("rst_after", 0);
  endtask

  task automatic test_width5;
    logic [2:0] e;
    int n;
    push_frame({3'b000, 5'b10011}, 5, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    @(posedge CLK); #1;
    p_data5 = 5'b10011; parity_enable = 1'b1; parity_type = 1'b0; stop_bits = 1'b0;
    baud_div = 8'd0; dv5 = 1'b1;
    @(posedge CLK); #1;
    dv5 = 1'b0; p_data5 = 5'b01100;
    n = 0;
    while (sq5.size() > 0) begin
      @(negedge CLK);
      e = sq5.pop_front();
      vec++;
      if ({done5, busy5, s5} !== e) begin
        err++;
        $display("FAIL width5 cyc %0d: tx_done/busy/S_DATA=%b want %b", n + 1, {done5, busy5, s5}, e);
      end
      n++;
    end
  endtask

  initial begin
    vec = 0; err = 0;
    RST = 1'b1; Data_Valid = 1'b0; dv5 = 1'b0; P_DATA = '0; p_data5 = '0;
    parity_enable = 1'b0; parity_type = 1'b0; stop_bits = 1'b0; baud_div = '0;
    test_reset;
    test_basic;
    test_parity;
    test_baud;
    test_back_to_back;
    test_mid_reset;
    test_width5;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, number of data bits per frame (legal 5..9).
REQ-002 SHALL provide parameter DIV_WIDTH, default 8, width of the baud divisor input.
REQ-003 SHALL provide port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-006 SHALL provide port Data_Valid  input  1  request to transmit P_DATA.
REQ-007 SHALL provide port parity_enable  input  1  1 = parity bit inserted after data.
REQ-008 SHALL provide port parity_type  input  1  0 = even, 1 = odd.
REQ-009 SHALL provide port stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 SHALL provide port baud_div  input  DIV_WIDTH  clocks per bit minus one (0 = one clock per bit).
REQ-011 SHALL provide port S_DATA  output  1  serial line, idle high.
REQ-012 SHALL provide port busy  output  1  high while a frame is in progress.
REQ-013 SHALL provide port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-015 SHALL accept a frame on the rising edge where state = IDLE and Data_Valid = 1; no other acceptance condition.
REQ-016 SHALL, on acceptance, latch P_DATA, parity_enable, parity_type, stop_bits and baud_div into internal registers; input changes during the frame have no effect.
REQ-017 SHALL, at the acceptance edge, enter START, drive S_DATA = 0 and busy = 1 (first start-bit cycle is the cycle after the edge).
REQ-018 SHALL hold every bit for exactly latched baud_div + 1 cycles, timed by a down-counter reloaded at each bit boundary.
REQ-019 SHALL transmit data bits LSB first, DATA_WIDTH bits, via a bit index counter 0..DATA_WIDTH-1.
REQ-020 SHALL, when latched parity_enable = 1, send parity = XOR of latched data (even) or its inverse (odd); otherwise skip PARITY from DATA directly to STOP.
REQ-021 SHALL drive S_DATA = 1 for one or two bit periods in STOP per latched stop_bits.
REQ-022 SHALL, at the edge ending the final stop bit period, return to IDLE, drive busy = 0, S_DATA = 1 and pulse tx_done = 1 for exactly one cycle.
REQ-023 SHALL give frame length (1 + DATA_WIDTH + P + S) x (baud_div + 1) cycles of busy, P = parity_enable, S = stop bits count.
REQ-024 SHALL ignore Data_Valid while busy; no queuing; a held Data_Valid is re-sampled in IDLE, giving back-to-back frames separated by exactly one IDLE cycle.
REQ-025 SHALL keep S_DATA = 1 in IDLE regardless of other inputs.

Reset
REQ-026 SHALL, on RST = 1 at any time including mid-frame, immediately force state IDLE, S_DATA = 1, busy = 0, tx_done = 0, all counters and latched registers 0.
REQ-027 SHALL not accept a frame on any edge where RST is high; first acceptance possible on the first edge after RST deasserts.

Verification
REQ-028 SHALL verify DATA_WIDTH=8, baud_div=0, parity off, 1 stop, P_DATA=0xA5 -> S_DATA 0,1,0,1,0,0,1,0,1,1 one cycle each; busy high 10 cycles; tx_done pulse on cycle 11.
REQ-029 SHALL verify 0xA5 with parity on: even -> parity bit 0, odd -> parity bit 1; busy 11 cycles.
REQ-030 SHALL verify baud_div=3, stop_bits=1, odd parity, P_DATA=0x0F -> each bit 4 cycles, parity bit 1, frame 48 cycles, two stop periods high.
REQ-031 SHALL verify Data_Valid held high with P_DATA changing 0x11->0x22 during frame -> only 0x11 sent, then 0x22 frame starts after one IDLE cycle.
REQ-032 SHALL verify RST asserted at cycle 5 of a baud_div=0 frame -> S_DATA=1, busy=0 asynchronously, no tx_done; next frame after release transmits correctly.
REQ-033 SHALL verify DATA_WIDTH=5 instance, P_DATA=5'b10011, even parity -> bits 0,1,1,0,0,1,1(parity),1; busy 8 cycles.
